vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Free-running 800x600@60 Hz raster timing generator at the head of the display pipeline. Produces the pixel coordinates, sync and blanking strobes that every drawing stage (background, cards, cursor) consumes and passes along on pclk. Also provides a frame-start pulse and a frame counter for animation and game-state logic.

## Interface
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels); H_TOTAL = 1056
- V_VISIBLE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = 628
- SYNC_POL, 1, sync active level (1 = active-high, 0 = active-low)
- pclk  in  1  pixel clock, 40 MHz; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- vcount  out  11  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- hblnk  out  1  high while hcount >= H_VISIBLE
- vblnk  out  1  high while vcount >= V_VISIBLE
- frame_start  out  1  one-cycle pulse coincident with (0,0) after a frame wrap
- frame_cnt  out  8  completed-frame counter, wraps 255->0

## Operation
- hcount increments every pclk; at H_TOTAL-1 wraps to 0 and vcount increments.
- vcount at V_TOTAL-1 together with hcount wrap -> vcount wraps to 0, frame_cnt increments (mod 256), frame_start asserted for exactly that cycle.
- hsync active for hcount in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC) = [840, 968).
- vsync active for vcount in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC) = [601, 605); transitions aligned with the hcount 1055->0 wrap.
- hblnk active for hcount in [800, 1055]; vblnk for vcount in [600, 627].
- All outputs registered; all strobes describe the same pixel as hcount/vcount in the same cycle (decode from next-count values, no one-cycle skew).
- Counter arithmetic unsigned 11-bit; counts never exceed TOTAL-1; no out-of-range state reachable.

## Timing
- Reset (asynchronous, immediate): hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, frame_cnt=0, hsync=vsync=inactive (~SYNC_POL).
- First rising edge after rst deasserts: hcount=1, vcount=0. First frame after reset produces no frame_start; first pulse at the first (1055,627)->(0,0) wrap.
- Line period 1056 cycles; frame period 1056*628 = 663168 cycles.
- rst asserted mid-frame: all outputs return to reset values without waiting for a clock edge; counting restarts from (0,0) after release.
- No enable or stall: generator never pauses.

## Structure
- Package vga_timing_pkg: timing constants (visible/porch/sync widths, derived totals and sync start/end), shared by this block and downstream drawing stages for bounds checks.
- One sub-module natural: mod_counter (parameterised modulus, increment enable, wrap output), instantiated twice: horizontal (always enabled) and vertical (enabled by horizontal wrap).
- Sync/blank decode and frame counter live in the top.

## Test plan
- Hold rst high, toggle pclk -> all outputs at reset values; hsync=vsync=0 with SYNC_POL=1, =1 with SYNC_POL=0.
- Release rst, run one line -> hblnk rises at hcount=800, hsync high on hcount 840..967, falls at 968; hcount 1055->0 with vcount 0->1.
- Run to line 600 -> vblnk rises with vcount=600; vsync high for vcount 601..604 exactly, edges coincident with hcount=0.
- Run one full frame -> frame_start single-cycle high at (0,0) after 663168 cycles from reset release minus 1; frame_cnt 0->1; no other frame_start pulses.
- Assert rst asynchronously at (400,300) between edges -> outputs reset immediately; after release counts resume from (0,0).
- Run 256 frames -> frame_cnt wraps 255->0 with frame_start still pulsing.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 raster constants; downstream drawing stages import these for bounds checks.
package vga_timing_pkg;

    localparam int unsigned CNT_W       = 32'd11;
    localparam int unsigned FRAME_CNT_W = 32'd8;

    localparam int unsigned H_VISIBLE = 32'd800;
    localparam int unsigned H_FP      = 32'd40;
    localparam int unsigned H_SYNC    = 32'd128;
    localparam int unsigned H_BP      = 32'd88;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 32'd600;
    localparam int unsigned V_FP      = 32'd1;
    localparam int unsigned V_SYNC    = 32'd4;
    localparam int unsigned V_BP      = 32'd23;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam bit SYNC_POL = 1'b1;

    // Half-open window test [lo, hi) on a raster coordinate.
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// Modulo-MOD up-counter with enable; exposes its next value so callers can decode without skew.
module mod_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MOD = H_TOTAL,
    parameter int unsigned W   = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] next_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 32'd1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count; >= rather than == so a corrupted count still falls back to zero.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_o = 1'b0;
        if (en_i) begin
            if (cnt_q >= LAST) begin
                cnt_d  = '0;
                wrap_o = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign next_o = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: coordinates, sync/blank strobes, frame pulse and counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned P_H_VISIBLE = H_VISIBLE,
    parameter int unsigned P_H_FP      = H_FP,
    parameter int unsigned P_H_SYNC    = H_SYNC,
    parameter int unsigned P_H_BP      = H_BP,
    parameter int unsigned P_V_VISIBLE = V_VISIBLE,
    parameter int unsigned P_V_FP      = V_FP,
    parameter int unsigned P_V_SYNC    = V_SYNC,
    parameter int unsigned P_V_BP      = V_BP,
    parameter bit          P_SYNC_POL  = SYNC_POL
) (
    input  logic                   pclk_i,
    input  logic                   rst_i,
    output logic [CNT_W-1:0]       hcount_o,
    output logic [CNT_W-1:0]       vcount_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   hblnk_o,
    output logic                   vblnk_o,
    output logic                   frame_start_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam int unsigned HT = P_H_VISIBLE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int unsigned VT = P_V_VISIBLE + P_V_FP + P_V_SYNC + P_V_BP;

    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(P_H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(P_V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_LO_C = CNT_W'(P_H_VISIBLE + P_H_FP);
    localparam logic [CNT_W-1:0] HS_HI_C = CNT_W'(P_H_VISIBLE + P_H_FP + P_H_SYNC);
    localparam logic [CNT_W-1:0] VS_LO_C = CNT_W'(P_V_VISIBLE + P_V_FP);
    localparam logic [CNT_W-1:0] VS_HI_C = CNT_W'(P_V_VISIBLE + P_V_FP + P_V_SYNC);
    localparam logic             SYNC_ACT = P_SYNC_POL;

    logic [CNT_W-1:0] h_next_s;
    logic [CNT_W-1:0] v_next_s;
    logic             h_wrap_s;
    logic             v_wrap_s;

    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   hblnk_q, hblnk_d;
    logic                   vblnk_q, vblnk_d;
    logic                   frame_start_q, frame_start_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    mod_counter #(.MOD(HT), .W(CNT_W)) u_hcnt (
        .clk_i  (pclk_i),
        .rst_i  (rst_i),
        .en_i   (1'b1),
        .cnt_o  (hcount_o),
        .next_o (h_next_s),
        .wrap_o (h_wrap_s)
    );

    mod_counter #(.MOD(VT), .W(CNT_W)) u_vcnt (
        .clk_i  (pclk_i),
        .rst_i  (rst_i),
        .en_i   (h_wrap_s),
        .cnt_o  (vcount_o),
        .next_o (v_next_s),
        .wrap_o (v_wrap_s)
    );

    // Strobes decoded from the next counts so they land in the same cycle as the coordinates.
    always_comb begin
        hblnk_d       = (h_next_s >= H_VIS_C);
        vblnk_d       = (v_next_s >= V_VIS_C);
        hsync_d       = in_window(h_next_s, HS_LO_C, HS_HI_C) ? SYNC_ACT : ~SYNC_ACT;
        vsync_d       = in_window(v_next_s, VS_LO_C, VS_HI_C) ? SYNC_ACT : ~SYNC_ACT;
        frame_start_d = h_wrap_s & v_wrap_s;
        if (h_wrap_s && v_wrap_s) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Output registers.
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign hblnk_o       = hblnk_q;
    assign vblnk_o       = vblnk_q;
    assign frame_start_o = frame_start_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a full-size instance for line timing and a shrunken instance for frame-level behaviour.
module tb_vga_timing_gen;

    // Shrunken geometry: H 12+2+3+3 = 20, sync [14,17); V 4+1+2+1 = 8, sync [5,7); active-low sync.
    localparam int SH_TOT = 20;
    localparam int SV_TOT = 8;
    localparam int S_FRAME = SH_TOT * SV_TOT;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [10:0] f_hcount, f_vcount, s_hcount, s_vcount;
    logic        f_hsync, f_vsync, f_hblnk, f_vblnk, f_fs;
    logic        s_hsync, s_vsync, s_hblnk, s_vblnk, s_fs;
    logic [7:0]  f_fcnt, s_fcnt;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    always #5 pclk = ~pclk;

    vga_timing_gen u_full (
        .pclk_i(pclk), .rst_i(rst),
        .hcount_o(f_hcount), .vcount_o(f_vcount),
        .hsync_o(f_hsync), .vsync_o(f_vsync),
        .hblnk_o(f_hblnk), .vblnk_o(f_vblnk),
        .frame_start_o(f_fs), .frame_cnt_o(f_fcnt)
    );

    vga_timing_gen #(
        .P_H_VISIBLE(12), .P_H_FP(2), .P_H_SYNC(3), .P_H_BP(3),
        .P_V_VISIBLE(4),  .P_V_FP(1), .P_V_SYNC(2), .P_V_BP(1),
        .P_SYNC_POL(1'b0)
    ) u_small (
        .pclk_i(pclk), .rst_i(rst),
        .hcount_o(s_hcount), .vcount_o(s_vcount),
        .hsync_o(s_hsync), .vsync_o(s_vsync),
        .hblnk_o(s_hblnk), .vblnk_o(s_vblnk),
        .frame_start_o(s_fs), .frame_cnt_o(s_fcnt)
    );

    task automatic step();
        @(posedge pclk);
        edges++;
        @(negedge pclk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        checks++;
        if ({f_hcount, f_vcount, f_hblnk, f_vblnk, f_fs, f_fcnt, f_hsync, f_vsync} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_full: got h=%0d v=%0d hb=%b vb=%b fs=%b fc=%0d hs=%b vs=%b, expected all zero",
                     f_hcount, f_vcount, f_hblnk, f_vblnk, f_fs, f_fcnt, f_hsync, f_vsync);
        end
        checks++;
        if ({s_hcount, s_vcount, s_hblnk, s_vblnk, s_fs, s_fcnt, s_hsync, s_vsync} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_small: got h=%0d v=%0d hb=%b vb=%b fs=%b fc=%0d hs=%b vs=%b, expected zeros with hs=vs=1",
                     s_hcount, s_vcount, s_hblnk, s_vblnk, s_fs, s_fcnt, s_hsync, s_vsync);
        end
        rst   = 1'b0;
        edges = 0;
    endtask

    task automatic test_first_line();
        logic [10:0] eh, ev;
        logic        ehs, ehb;
        for (int k = 1; k <= 1056; k++) begin
            step();
            eh  = 11'(edges % 1056);
            ev  = 11'(edges / 1056);
            ehb = (eh >= 11'd800);
            ehs = (eh >= 11'd840) && (eh < 11'd968);
            checks++;
            if (f_hcount !== eh || f_vcount !== ev) begin
                errors++;
                $display("FAIL line_count edge %0d: got (%0d,%0d) expected (%0d,%0d)", edges, f_hcount, f_vcount, eh, ev);
            end
            checks++;
            if (f_hblnk !== ehb || f_hsync !== ehs) begin
                errors++;
                $display("FAIL line_strobes h=%0d: got hblnk=%b hsync=%b expected hblnk=%b hsync=%b", eh, f_hblnk, f_hsync, ehb, ehs);
            end
            checks++;
            if (f_vblnk !== 1'b0 || f_vsync !== 1'b0 || f_fs !== 1'b0 || f_fcnt !== 8'd0) begin
                errors++;
                $display("FAIL line_vert h=%0d: got vblnk=%b vsync=%b fs=%b fc=%0d expected 0 0 0 0", eh, f_vblnk, f_vsync, f_fs, f_fcnt);
            end
        end
    endtask

    task automatic test_small_raster(input int until_edge);
        int          pos;
        logic [10:0] eh, ev;
        logic        ehs, evs, ehb, evb, efs;
        logic [7:0]  efc;
        while (edges < until_edge) begin
            step();
            pos = edges % S_FRAME;
            eh  = 11'(pos % SH_TOT);
            ev  = 11'(pos / SH_TOT);
            ehs = !((eh >= 11'd14) && (eh < 11'd17));
            evs = !((ev >= 11'd5) && (ev < 11'd7));
            ehb = (eh >= 11'd12);
            evb = (ev >= 11'd4);
            efs = (pos == 0);
            efc = 8'((edges / S_FRAME) % 256);
            checks++;
            if (s_hcount !== eh || s_vcount !== ev) begin
                errors++;
                $display("FAIL small_count edge %0d: got (%0d,%0d) expected (%0d,%0d)", edges, s_hcount, s_vcount, eh, ev);
            end
            checks++;
            if ({s_hsync, s_vsync, s_hblnk, s_vblnk} !== {ehs, evs, ehb, evb}) begin
                errors++;
                $display("FAIL small_strobes (%0d,%0d): got hs=%b vs=%b hb=%b vb=%b expected hs=%b vs=%b hb=%b vb=%b",
                         eh, ev, s_hsync, s_vsync, s_hblnk, s_vblnk, ehs, evs, ehb, evb);
            end
            checks++;
            if (s_fs !== efs || s_fcnt !== efc) begin
                errors++;
                $display("FAIL small_frame edge %0d: got fs=%b fc=%0d expected fs=%b fc=%0d", edges, s_fs, s_fcnt, efs, efc);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while ((edges % 1056) != 400 && guard < 1100) begin
            step();
            guard++;
        end
        checks++;
        if (f_hcount !== 11'd400) begin
            errors++;
            $display("FAIL pre_reset_pos: got hcount=%0d expected 400", f_hcount);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({f_hcount, f_vcount, f_hblnk, f_vblnk, f_fs, f_fcnt, f_hsync, f_vsync} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_full: got h=%0d v=%0d fc=%0d hs=%b vs=%b, expected zeros",
                     f_hcount, f_vcount, f_fcnt, f_hsync, f_vsync);
        end
        checks++;
        if ({s_hcount, s_vcount, s_fcnt, s_hsync, s_vsync} !== {11'd0, 11'd0, 8'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL async_reset_small: got h=%0d v=%0d fc=%0d hs=%b vs=%b, expected 0 0 0 1 1",
                     s_hcount, s_vcount, s_fcnt, s_hsync, s_vsync);
        end
        @(posedge pclk);
        @(negedge pclk);
        checks++;
        if (f_hcount !== 11'd0 || s_hcount !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got full h=%0d small h=%0d expected 0 0", f_hcount, s_hcount);
        end
        rst   = 1'b0;
        edges = 0;
        step();
        checks++;
        if ({f_hcount, f_vcount, s_hcount, s_vcount} !== {11'd1, 11'd0, 11'd1, 11'd0}) begin
            errors++;
            $display("FAIL restart: got full (%0d,%0d) small (%0d,%0d) expected (1,0) (1,0)",
                     f_hcount, f_vcount, s_hcount, s_vcount);
        end
    endtask

    task automatic test_frame_wrap();
        int         pulses = 0;
        int         pos;
        logic       efs;
        logic [7:0] efc;
        while (edges < 256 * S_FRAME + 3) begin
            step();
            pos = edges % S_FRAME;
            efs = (pos == 0);
            efc = 8'((edges / S_FRAME) % 256);
            if (s_fs === 1'b1) pulses++;
            checks++;
            if (s_fs !== efs || s_fcnt !== efc) begin
                errors++;
                $display("FAIL wrap_frame edge %0d: got fs=%b fc=%0d expected fs=%b fc=%0d", edges, s_fs, s_fcnt, efs, efc);
            end
            if (edges == 256 * S_FRAME) begin
                checks++;
                if (s_fcnt !== 8'd0 || s_hcount !== 11'd0 || s_vcount !== 11'd0) begin
                    errors++;
                    $display("FAIL wrap_255_to_0: got fc=%0d at (%0d,%0d) expected 0 at (0,0)", s_fcnt, s_hcount, s_vcount);
                end
            end
        end
        checks++;
        if (pulses != 256) begin
            errors++;
            $display("FAIL pulse_count: got %0d frame_start pulses expected 256", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_small_raster(edges + 2 * S_FRAME + 5);
        test_async_reset();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
